bus_sequencer: RTL
==================

BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001: Parameter NUM_REGS, default 4, number of general registers on the transfer bus; fixed at 4 in this revision.
REQ-002: i_clk  input  1  single clock; all state changes on rising edge.
REQ-003: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004: i_cmd_valid  input  1  command request.
REQ-005: o_cmd_ready  output  1  sequencer can accept a command.
REQ-006: i_cmd_op  input  2  00 MOV, 01 ALU, 10 LDI (load immediate), 11 reserved.
REQ-007: i_cmd_src  input  2  source register index; left operand for ALU.
REQ-008: i_cmd_rhs  input  2  right operand register index; ALU only.
REQ-009: i_cmd_dst  input  2  destination register index.
REQ-010: i_cmd_imm  input  8  immediate value; LDI only.
REQ-011: o_assert_transfer  output  4  one-hot per-register transfer-bus drive enable.
REQ-012: o_assert_left / o_assert_right  output  4 each  one-hot per-register ALU operand bus enables.
REQ-013: o_load_transfer  output  4  one-hot per-register load strobe; the register latches on the falling edge.
REQ-014: o_alu_assert  output  1  ALU result drives the transfer bus.
REQ-015: transfer_bus  inout  8  driven with the immediate during LDI; high-Z otherwise.
REQ-016: o_busy  output  1  command in flight.
REQ-017: o_done  output  1  one-cycle completion pulse.
REQ-018: o_error  output  1  one-cycle pulse on a reserved op.

Function
REQ-019: The FSM SHALL have states IDLE, DRIVE, LOAD, RELEASE and ERR.
REQ-020: o_cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a rising edge with i_cmd_valid & o_cmd_ready, and all cmd fields SHALL be captured at that edge.
REQ-021: On acceptance, the FSM SHALL go IDLE->DRIVE for op 00/01/10 and IDLE->ERR for op 11.
REQ-022: Sequence: DRIVE->LOAD->RELEASE->IDLE, one cycle each; accept to return to IDLE takes 4 cycles, and commands SHALL be accepted at most every 4 cycles.
REQ-023: The source driver SHALL be asserted in DRIVE, LOAD and RELEASE, and deasserted in IDLE.
- MOV: o_assert_transfer[src].
- ALU: o_assert_left[src], o_assert_right[rhs] and o_alu_assert.
- LDI: transfer_bus = captured imm.
REQ-024: o_load_transfer[dst] SHALL be 1 only in LOAD, so that its falling edge (LOAD->RELEASE) occurs while the source is still driving.
REQ-025: At most one transfer-bus driver (any o_assert_transfer bit, o_alu_assert, or the imm drive) SHALL be active in any cycle, and at most one o_load_transfer bit SHALL be active in any cycle.
REQ-026: MOV with src==dst SHALL execute the full sequence (harmless self-load); ALU with src==rhs SHALL assert the same index on both the left and right buses.
REQ-027: o_busy SHALL be 1 in DRIVE, LOAD and RELEASE.
REQ-028: o_done SHALL be 1 for exactly the RELEASE cycle.
REQ-029: ERR SHALL last one cycle with o_error=1 and no strobes or drivers active, then return to IDLE.
REQ-030: i_cmd_valid while not ready SHALL be ignored; the requester holds it until accepted.
REQ-031: All outputs SHALL be registered (Moore) and glitch-free.

Reset
REQ-032: On i_rst_n=0, asynchronously: state IDLE; all enables and strobes 0; o_busy=0, o_done=0, o_error=0; transfer_bus high-Z.
REQ-033: After reset deassertion, o_cmd_ready SHALL be 1 from the first rising edge.
REQ-034: Reset during LOAD SHALL force o_load_transfer low; the resulting falling edge on the destination is accepted behaviour, and the command is dropped with no o_done.

Verification
REQ-035: MOV src=1 dst=3 accepted at cycle 0.
- Cycles 1-3: o_assert_transfer=0010.
- Cycle 2: o_load_transfer=1000.
- Cycle 3: o_done=1.
- Cycle 4: all outputs 0 and ready=1.
REQ-036: LDI imm=8'hA5 dst=0: transfer_bus=A5 in cycles 1-3, o_load_transfer=0001 in cycle 2, and transfer_bus high-Z in cycle 4.
REQ-037: ALU src=2 rhs=2 dst=2: left=0100, right=0100, o_alu_assert=1 in cycles 1-3, load=0100 in cycle 2, and o_assert_transfer=0 throughout.
REQ-038: op=11: ready=0 and o_error=1 for one cycle, no strobes, and ready=1 on the next cycle.
REQ-039: Back-to-back valid held high for two MOVs: second acceptance at cycle 4, and the bus-driver one-hot check passes on every cycle.
REQ-040: i_rst_n low mid-LOAD (asynchronous, between edges): all outputs 0 immediately, no o_done, and ready=1 after release.

Source files
------------

// File: rtl/bus_sequencer.sv
// Register-transfer bus sequencer: runs each MOV/ALU/LDI command as a fixed
// DRIVE -> LOAD -> RELEASE sequence, so that a load strobe falls while its source is still driving.
module bus_sequencer #(
    parameter int NUM_REGS = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [1:0]          i_cmd_op,
    input  logic [1:0]          i_cmd_src,
    input  logic [1:0]          i_cmd_rhs,
    input  logic [1:0]          i_cmd_dst,
    input  logic [7:0]          i_cmd_imm,
    output logic [NUM_REGS-1:0] o_assert_transfer,
    output logic [NUM_REGS-1:0] o_assert_left,
    output logic [NUM_REGS-1:0] o_assert_right,
    output logic [NUM_REGS-1:0] o_load_transfer,
    output logic                o_alu_assert,
    inout  wire  [7:0]          transfer_bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_LOAD, S_RELEASE, S_ERR} state_t;
    typedef enum logic [1:0] {OP_MOV = 2'b00, OP_ALU = 2'b01, OP_LDI = 2'b10, OP_RSV = 2'b11} op_t;

    localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

    state_t state, next_state;
    op_t        op_q, op_sel;
    logic [1:0] src_q, rhs_q, dst_q, src_sel, rhs_sel, dst_sel;
    logic [7:0] imm_q;
    logic       accept;
    logic       imm_drive;

    logic [NUM_REGS-1:0] nx_assert_transfer, nx_assert_left, nx_assert_right, nx_load_transfer;
    logic                nx_alu_assert, nx_imm_drive, nx_busy, nx_done, nx_error, nx_ready;

    assign accept = i_cmd_valid & o_cmd_ready;

    // On the accepting edge the DRIVE outputs come straight from the command inputs.
    assign op_sel  = accept ? op_t'(i_cmd_op) : op_q;
    assign src_sel = accept ? i_cmd_src : src_q;
    assign rhs_sel = accept ? i_cmd_rhs : rhs_q;
    assign dst_sel = accept ? i_cmd_dst : dst_q;

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:    if (accept) next_state = (op_t'(i_cmd_op) == OP_RSV) ? S_ERR : S_DRIVE;
            S_DRIVE:   next_state = S_LOAD;
            S_LOAD:    next_state = S_RELEASE;
            S_RELEASE: next_state = S_IDLE;
            S_ERR:     next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from next_state and then registered, so every pin is a flop output.
    always_comb begin
        // NOTE: every output gets a default first so no path through this block can infer a latch.
        nx_assert_transfer = '0;
        nx_assert_left     = '0;
        nx_assert_right    = '0;
        nx_load_transfer   = '0;
        nx_alu_assert      = 1'b0;
        nx_imm_drive       = 1'b0;
        nx_ready           = (next_state == S_IDLE);
        nx_busy            = (next_state == S_DRIVE) || (next_state == S_LOAD) ||
                             (next_state == S_RELEASE);
        nx_done            = (next_state == S_RELEASE);
        nx_error           = (next_state == S_ERR);
        if (nx_busy) begin
            unique case (op_sel)
                OP_MOV:  nx_assert_transfer = ONE << src_sel;
                OP_ALU: begin
                    nx_assert_left  = ONE << src_sel;
                    nx_assert_right = ONE << rhs_sel;
                    nx_alu_assert   = 1'b1;
                end
                OP_LDI:  nx_imm_drive = 1'b1;
                default: ;
            endcase
        end
        if (next_state == S_LOAD) nx_load_transfer = ONE << dst_sel;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= S_IDLE;
            op_q              <= OP_MOV;
            src_q             <= '0;
            rhs_q             <= '0;
            dst_q             <= '0;
            imm_q             <= '0;
            o_cmd_ready       <= 1'b0;
            o_assert_transfer <= '0;
            o_assert_left     <= '0;
            o_assert_right    <= '0;
            o_load_transfer   <= '0;
            o_alu_assert      <= 1'b0;
            imm_drive         <= 1'b0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_error           <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_q  <= op_t'(i_cmd_op);
                src_q <= i_cmd_src;
                rhs_q <= i_cmd_rhs;
                dst_q <= i_cmd_dst;
                imm_q <= i_cmd_imm;
            end
            o_cmd_ready       <= nx_ready;
            o_assert_transfer <= nx_assert_transfer;
            o_assert_left     <= nx_assert_left;
            o_assert_right    <= nx_assert_right;
            o_load_transfer   <= nx_load_transfer;
            o_alu_assert      <= nx_alu_assert;
            imm_drive         <= nx_imm_drive;
            o_busy            <= nx_busy;
            o_done            <= nx_done;
            o_error           <= nx_error;
        end
    end

    assign transfer_bus = imm_drive ? imm_q : 8'bz;

endmodule
